// File: rtl/dec2of5_rx.sv
// dec2of5_rx - serial 2-of-5 (POSTNET-weighted) code receiver and decoder.
//
// Waits in HUNT for a frame-start mark, then shifts 5-bit codewords in
// MSB-first (weights 7,4,2,1,0) on every strobed bit. Each completed word is
// checked for exactly two ones and decoded to a BCD digit. The digit and error
// flag are registered and presented with a one-cycle valid pulse. Words follow
// back-to-back without a new frame start.
//
// Ports:
//   CK    in   rising-edge clock
//   CLRN  in   asynchronous active-low reset
//   FS    in   frame start: (re)starts a frame and discards any partial word
//   SV    in   serial bit strobe; SD is sampled when SV=1
//   SD    in   serial data bit, MSB first
//   DIG   out  [3:0] decoded BCD digit, 4'hF on an invalid word
//   DV    out  one-cycle pulse when a word has been decoded
//   ERR   out  qualifies DV: word did not have exactly two ones
//   BUSY  out  high while 1..4 bits of a word are held
//   SUM   out  [3:0] running mod-10 sum of valid digits (DEC25_CKSUM_EN)
//   SOK   out  SUM==0 after at least one word (DEC25_CKSUM_EN)
//
// Build option: define DEC25_CKSUM_EN to build the SUM/SOK checksum logic.
module dec2of5_rx (
  input  logic       CK,
  input  logic       CLRN,
  input  logic       FS,
  input  logic       SV,
  input  logic       SD,
  output logic [3:0] DIG,
  output logic       DV,
  output logic       ERR,
`ifdef DEC25_CKSUM_EN
  output logic       BUSY,
  output logic [3:0] SUM,
  output logic       SOK
`else
  output logic       BUSY
`endif
);

  typedef enum logic {HUNT = 1'b0, RX = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  // Only four bits are held; the fifth arrives on SD and completes the word.
  logic [3:0]  sh_q, sh_d;
  logic [3:0]  dig_q, dig_d;
  logic        dv_q, dv_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [4:0]  word;
  logic [3:0]  dec;

`ifdef DEC25_CKSUM_EN
  logic [3:0]  sum_q, sum_d;
  logic        sok_q, sok_d;
`endif

  // Every two-ones pattern has a digit, so the default arm is exactly the
  // wrong-popcount case.
  function automatic logic [3:0] decode(input logic [4:0] w);
    logic [3:0] d;
    case (w)
      5'b11000: d = 4'd0;
      5'b00011: d = 4'd1;
      5'b00101: d = 4'd2;
      5'b00110: d = 4'd3;
      5'b01001: d = 4'd4;
      5'b01010: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b10001: d = 4'd7;
      5'b10010: d = 4'd8;
      5'b10100: d = 4'd9;
      default:  d = 4'hF;
    endcase
    return d;
  endfunction

`ifdef DEC25_CKSUM_EN
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction
`endif

  assign word = {sh_q, SD};
  assign dec  = decode(word);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    err_d   = err_q;
    dv_d    = 1'b0;
`ifdef DEC25_CKSUM_EN
    sum_d   = sum_q;
    sok_d   = sok_q;
`endif
    if (FS) begin
      // Frame start wins over everything, including a completing bit; a
      // simultaneous strobe becomes bit 0 of the fresh word.
      state_d = RX;
      cnt_d   = SV ? 3'd1 : 3'd0;
      sh_d    = SV ? {3'b000, SD} : 4'b0000;
`ifdef DEC25_CKSUM_EN
      sum_d   = 4'd0;
      sok_d   = 1'b0;
`endif
    end else if (state_q == RX && SV) begin
      if (cnt_q == 3'd4) begin
        cnt_d = 3'd0;
        sh_d  = 4'b0000;
        dv_d  = 1'b1;
        dig_d = dec;
        err_d = (dec == 4'hF);
`ifdef DEC25_CKSUM_EN
        if (dec != 4'hF) sum_d = add_mod10(sum_q, dec);
        sok_d = (sum_d == 4'd0);
`endif
      end else begin
        cnt_d = cnt_q + 3'd1;
        sh_d  = word[3:0];
      end
    end
    busy_d = (cnt_d != 3'd0);
  end

  always_ff @(posedge CK or negedge CLRN) begin
    if (!CLRN) begin
      state_q <= HUNT;
      cnt_q   <= 3'd0;
      sh_q    <= 4'b0000;
      dig_q   <= 4'd0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DEC25_CKSUM_EN
      sum_q   <= 4'd0;
      sok_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef DEC25_CKSUM_EN
      sum_q   <= sum_d;
      sok_q   <= sok_d;
`endif
    end
  end

  assign DIG  = dig_q;
  assign DV   = dv_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;
`ifdef DEC25_CKSUM_EN
  assign SUM  = sum_q;
  assign SOK  = sok_q;
`endif

endmodule

// File: doc/dec2of5_rx.md
# dec2of5_rx

Serial 2-of-5 (POSTNET-weighted) code receiver and decoder: the receive end of the 2-of-5 encoder link. It captures 5-bit codewords MSB-first from a strobed serial line after a frame-start mark. It validates each word as exactly two ones and emits a registered BCD digit with a one-cycle valid pulse and an error flag. It sits between the serial line interface and downstream digit/display logic in the lab projects.

## Interface
- No parameters; code mapping and word length (5) are fixed.
- CK  input  1  rising-edge clock.
- CLRN  input  1  asynchronous active-low reset.
- FS  input  1  frame start; begins a new frame and word.
- SV  input  1  serial bit strobe; SD is sampled when SV=1.
- SD  input  1  serial data bit, MSB (weight 7) first.
- DIG  output  4  decoded BCD digit; 4'hF on invalid word.
- DV  output  1  one-cycle pulse: new word decoded.
- ERR  output  1  qualifies DV: word did not have exactly two ones.
- BUSY  output  1  high while a word is partially received (1-4 bits held).
- SUM  output  4  running mod-10 digit sum (DEC25_CKSUM_EN only).
- SOK  output  1  SUM==0 and at least one word received (DEC25_CKSUM_EN only).

## Operation
- States: HUNT (after reset, ignores SV/SD until FS) and RX (shifting bits).
- HUNT -> RX on FS=1. In RX, FS=1 restarts: bit count cleared, partial word discarded.
- FS with SV in the same cycle: SD is bit 0 of the new word (FS priority, then sample).
- RX: each SV=1 cycle shifts SD into 5-bit shift register, 3-bit count 0..4. On the 5th bit, count wraps to 0, state stays RX (back-to-back words need no new FS).
- Mapping (bits w7 w4 w2 w1 w0): 11000=0, 00011=1, 00101=2, 00110=3, 01001=4, 01010=5, 01100=6, 10001=7, 10010=8, 10100=9.
- Any word with popcount != 2: DIG=4'hF, ERR=1. The mapping covers all 10 two-ones words, so an invalid word means a wrong popcount.
- DIG/ERR hold their values until the next completed word. ERR is meaningful only with DV; it holds after DV.
- SV=0 cycles stall the receiver indefinitely; no timeout.
- Reset values: state HUNT, count 0, shift register 0, DIG=0, DV=0, ERR=0, BUSY=0, SUM=0, SOK=0.
- CLRN low mid-word aborts asynchronously. The partial word is lost and no DV is issued.

## Timing
- Registered outputs only. DV rises at the CK edge that samples the 5th bit (DIG/ERR update on the same edge). DV falls on the next edge.
- Latency: the 5th-bit sample edge produces outputs at that edge plus clock-to-Q. Min word period is 5 cycles, so DV pulses are at least 5 cycles apart.
- BUSY is high after edges leaving count 1..4. It is low in HUNT and after word completion.
- FS asserted on the edge that would complete a word: the restart wins, no DV.

## Configuration
- DEC25_CKSUM_EN defined:
  - SUM accumulates (SUM + DIG) mod 10 on every valid DV (ERR=0). Invalid words leave SUM unchanged.
  - FS clears SUM and SOK.
  - SOK updates with SUM, on the same edge as DV.
- DEC25_CKSUM_EN undefined: SUM and SOK are absent and their logic is not built. All other behaviour is identical.

## Test plan
- Reset, FS, then serial 00101 with SV every cycle -> DV one cycle at the 5th sample, DIG=2, ERR=0. BUSY high for 4 cycles before that.
- Back-to-back 11000 then 10100 without a second FS -> two DV pulses 5 cycles apart, DIG=0 then 9.
- Word 11100 -> DV=1, ERR=1, DIG=4'hF. Next word 01001 -> DIG=4, ERR=0.
- SV before any FS -> no DV, BUSY=0. FS after 3 bits of a word, then 00011 -> exactly one DV, DIG=1.
- CLRN pulsed low after 2 bits -> all outputs 0, state HUNT; subsequent SV bits ignored until FS.
- DEC25_CKSUM_EN: FS, digits 3,7, then invalid 11110 -> SUM=0, SOK=1 after the 7. Invalid word leaves SUM=0. A further FS -> SOK=0.
